// File: rtl/tx_arp_resolver.sv
// ARP front end for the XGMII port-0 test-frame generator: resolves the gateway MAC,
// retrying on timeout, then hands it to the generator and enables IPv4 test traffic.
module tx_arp_resolver #(
    parameter int unsigned TIMEOUT_CYCLES = 156250,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [47:0] DEFAULT_MAC    = 48'hffffffffffff
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tx_enable,
    input  logic        req_arp,
    input  logic [31:0] gw_ip,
    input  logic [31:0] src_ip,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        arp_tx_req,
    input  logic        arp_tx_ack,
    output logic [47:0] dst_mac,
    output logic        arp_resolved,
    output logic        v4_send_en,
    output logic        arp_fail,
    output logic [7:0]  arp_retry_count
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResolved, StFail} state_t;

    localparam logic [7:0]  MaxRetry  = 8'(MAX_RETRY);
    localparam logic [31:0] TimerLoad = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] timer;

    // Parser: word_idx 0 = hunting for a start word, 1..6 = next expected frame word.
    logic [2:0]  word_idx;
    logic [47:0] sender_mac;
    logic        reply_valid;
    logic        is_start;
    logic        word_ok;

    assign is_start = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hfb);

    always_comb begin
        word_ok = (xgmii_rxc == 8'h00);
        case (word_idx)
            3'd2: word_ok = word_ok && (xgmii_rxd[39:32] == 8'h08)
                                    && (xgmii_rxd[47:40] == 8'h06);
            3'd3: word_ok = word_ok && (xgmii_rxd[39:32] == 8'h00)
                                    && (xgmii_rxd[47:40] == 8'h02);
            3'd4: word_ok = word_ok && (xgmii_rxd[39:32] == gw_ip[31:24])
                                    && (xgmii_rxd[47:40] == gw_ip[23:16])
                                    && (xgmii_rxd[55:48] == gw_ip[15:8])
                                    && (xgmii_rxd[63:56] == gw_ip[7:0]);
            3'd5: word_ok = word_ok && (xgmii_rxd[55:48] == src_ip[31:24])
                                    && (xgmii_rxd[63:56] == src_ip[23:16]);
            3'd6: word_ok = word_ok && (xgmii_rxd[7:0] == src_ip[15:8])
                                    && (xgmii_rxd[15:8] == src_ip[7:0]);
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_idx    <= 3'd0;
            sender_mac  <= '0;
            reply_valid <= 1'b0;
        end else begin
            reply_valid <= 1'b0;
            if (is_start) begin
                word_idx <= 3'd1;
            end else if (word_idx != 3'd0) begin
                if (!word_ok) begin
                    word_idx <= 3'd0;
                end else if (word_idx == 3'd6) begin
                    word_idx    <= 3'd0;
                    reply_valid <= 1'b1;
                end else begin
                    word_idx <= word_idx + 3'd1;
                end
                if (word_idx == 3'd3) begin
                    sender_mac[47:32] <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
                end
                if (word_idx == 3'd4) begin
                    sender_mac[31:0] <= {xgmii_rxd[7:0], xgmii_rxd[15:8],
                                         xgmii_rxd[23:16], xgmii_rxd[31:24]};
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= StIdle;
            timer           <= '0;
            dst_mac         <= DEFAULT_MAC;
            arp_tx_req      <= 1'b0;
            arp_resolved    <= 1'b0;
            v4_send_en      <= 1'b0;
            arp_fail        <= 1'b0;
            arp_retry_count <= '0;
        end else if (!tx_enable) begin
            // Abort from anywhere; the resolved MAC and retry count stay visible.
            state        <= StIdle;
            arp_tx_req   <= 1'b0;
            arp_resolved <= 1'b0;
            v4_send_en   <= 1'b0;
            arp_fail     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_arp) begin
                        state           <= StReq;
                        arp_tx_req      <= 1'b1;
                        arp_retry_count <= '0;
                    end else begin
                        state        <= StResolved;
                        arp_resolved <= 1'b1;
                        v4_send_en   <= 1'b1;
                    end
                end
                StReq: begin
                    if (arp_tx_ack) begin
                        state      <= StWait;
                        arp_tx_req <= 1'b0;
                        timer      <= TimerLoad;
                    end
                end
                StWait: begin
                    // A reply arriving on the timeout cycle still wins.
                    if (reply_valid) begin
                        dst_mac      <= sender_mac;
                        state        <= StResolved;
                        arp_resolved <= 1'b1;
                        v4_send_en   <= 1'b1;
                    end else if (timer == 32'd0) begin
                        if (arp_retry_count >= MaxRetry) begin
                            state    <= StFail;
                            arp_fail <= 1'b1;
                        end else begin
                            arp_retry_count <= arp_retry_count + 8'd1;
                            state           <= StReq;
                            arp_tx_req      <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                StResolved, StFail: ;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
